// File: rtl/alu_mdu_pkg.sv
// Shared op-code encodings, FSM state type and op-class helper for alu_mdu.
package alu_mdu_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_JALR   = 5'd10;
    localparam logic [4:0] OP_BEQ    = 5'd11;
    localparam logic [4:0] OP_BNE    = 5'd12;
    localparam logic [4:0] OP_BLT    = 5'd13;
    localparam logic [4:0] OP_BGE    = 5'd14;
    localparam logic [4:0] OP_BLTU   = 5'd15;
    localparam logic [4:0] OP_BGEU   = 5'd16;
    localparam logic [4:0] OP_MUL    = 5'd17;
    localparam logic [4:0] OP_MULH   = 5'd18;
    localparam logic [4:0] OP_MULHSU = 5'd19;
    localparam logic [4:0] OP_MULHU  = 5'd20;
    localparam logic [4:0] OP_DIV    = 5'd21;
    localparam logic [4:0] OP_DIVU   = 5'd22;
    localparam logic [4:0] OP_REM    = 5'd23;
    localparam logic [4:0] OP_REMU   = 5'd24;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-subtract step
// per cycle on operand magnitudes, sign fixup applied combinationally at the end.
module alu_mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_step,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_last,
    output logic [XLEN-1:0] o_result
);
    localparam int CW = $clog2(XLEN) + 1;

    logic [4:0]        r_op;
    logic              r_div, r_negq, r_negr, r_dz;
    logic [XLEN-1:0]   r_hi, r_lo, r_opnd;
    logic [CW-1:0]     r_cnt;

    logic              w_sa_en, w_sb_en, w_sa, w_sb, w_isdiv, w_ge;
    logic [XLEN-1:0]   w_ma, w_mb;
    logic [XLEN:0]     w_madd, w_shift, w_trial;
    logic [2*XLEN-1:0] w_prod, w_prodf;

    assign w_sa_en = (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                     (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_sb_en = (i_op == OP_MUL) || (i_op == OP_MULH) ||
                     (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_sa    = w_sa_en && i_a[XLEN-1];
    assign w_sb    = w_sb_en && i_b[XLEN-1];
    assign w_ma    = w_sa ? -i_a : i_a;
    assign w_mb    = w_sb ? -i_b : i_b;
    assign w_isdiv = (i_op >= OP_DIV);

    // hi:lo is the running product (mul) or remainder:quotient (div)
    assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_opnd};
    // a zero divisor always "fits", so the remainder ends up holding the dividend
    assign w_ge    = r_dz || !w_trial[XLEN];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_op   <= i_op;
            r_div  <= w_isdiv;
            r_dz   <= w_isdiv && (i_b == '0);
            r_negq <= w_sa ^ w_sb;
            r_negr <= w_sa;
            r_hi   <= '0;
            r_lo   <= w_ma;
            r_opnd <= w_mb;
            r_cnt  <= CW'(XLEN);
        end else if (i_step) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_div) begin
                r_hi <= w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], w_ge};
            end else begin
                r_hi <= w_madd[XLEN:1];
                r_lo <= {w_madd[0], r_lo[XLEN-1:1]};
            end
        end
    end

    assign o_last  = (r_cnt == CW'(1));
    assign w_prod  = {r_hi, r_lo};
    assign w_prodf = r_negq ? -w_prod : w_prod;

    always_comb begin
        o_result = '0;
        case (r_op)
            OP_MUL:                       o_result = w_prodf[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: o_result = w_prodf[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              o_result = r_dz ? '1 : (r_negq ? -r_lo : r_lo);
            OP_REM, OP_REMU:              o_result = r_negr ? -r_hi : r_hi;
            default:                      o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mdu.sv
// XLEN-wide ALU with valid/ready handshake and registered output stage.
// Define ALU_MDU_MULDIV_EN to add the iterative M-extension multiply/divide.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            br_taken,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);

    state_e          r_state, w_state_nxt;
    logic            r_out_valid, r_br, r_ill;
    logic [XLEN-1:0] r_result;

    logic            w_accept, w_md, w_br, w_ill;
    logic [XLEN-1:0] w_res, w_sum;
    logic [SHW-1:0]  w_shamt;

    assign in_ready  = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign br_taken  = r_br;
    assign illegal   = r_ill;

`ifdef ALU_MDU_MULDIV_EN
    logic            w_it_last;
    logic [XLEN-1:0] w_it_result;

    assign w_md = is_muldiv(op);

    alu_mdu_iter #(.XLEN(XLEN)) u_iter (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_start  (w_accept && w_md),
        .i_step   (r_state == BUSY),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .o_last   (w_it_last),
        .o_result (w_it_result)
    );
`else
    assign w_md = 1'b0;
`endif

    assign w_sum   = a + b;
    assign w_shamt = b[SHW-1:0];

    always_comb begin
        w_res = '0;
        w_br  = 1'b0;
        w_ill = 1'b0;
        case (op)
            OP_ADD:  w_res = w_sum;
            OP_SUB:  w_res = a - b;
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_SLL:  w_res = a << w_shamt;
            OP_SRL:  w_res = a >> w_shamt;
            OP_SRA:  w_res = $signed(a) >>> w_shamt;
            OP_SLT:  w_res = XLEN'($signed(a) < $signed(b));
            OP_SLTU: w_res = XLEN'(a < b);
            OP_JALR: w_res = {w_sum[XLEN-1:1], 1'b0};
            OP_BEQ:  w_br  = (a == b);
            OP_BNE:  w_br  = (a != b);
            OP_BLT:  w_br  = ($signed(a) < $signed(b));
            OP_BGE:  w_br  = ($signed(a) >= $signed(b));
            OP_BLTU: w_br  = (a < b);
            OP_BGEU: w_br  = (a >= b);
            // unused encodings, and M ops when the iterative unit is absent
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_md) w_state_nxt = BUSY;
`ifdef ALU_MDU_MULDIV_EN
            BUSY:    if (w_it_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_br        <= 1'b0;
            r_ill       <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            if (w_accept && !w_md) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_br        <= w_br;
                r_ill       <= w_ill;
            end
`ifdef ALU_MDU_MULDIV_EN
            if (r_state == DONE) begin
                r_out_valid <= 1'b1;
                r_result    <= w_it_result;
                r_br        <= 1'b0;
                r_ill       <= 1'b0;
            end
`endif
        end
    end

endmodule
